// File: rtl/gerenciador_ativos_ctrl.sv
// Active-node slot manager: maps each update/deactivate request onto a registered
// one-hot enable for exactly one NA slot, chosen from the slot array's reported state.
module gerenciador_ativos_ctrl #(
  parameter int unsigned NUM_NA    = 8,
  parameter int unsigned ADR_WIDTH = 5
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        desativar_in,
  input  logic                        atualizar_in,
  input  logic [ADR_WIDTH-1:0]        endereco_in,
  input  logic [ADR_WIDTH*NUM_NA-1:0] na_endereco_in,
  input  logic [NUM_NA-1:0]           na_ativo_in,
  output logic [NUM_NA-1:0]           habilitar_out
);

  logic [NUM_NA-1:0] match_vec;
  logic [NUM_NA-1:0] free_vec;
  logic [NUM_NA-1:0] match_sel;
  logic [NUM_NA-1:0] free_sel;
  logic [NUM_NA-1:0] habilitar_d;
  logic [NUM_NA-1:0] habilitar_q;

  always_comb begin
    match_vec = '0;
    free_vec  = '0;
    for (int unsigned i = 0; i < NUM_NA; i++) begin
      match_vec[i] = na_ativo_in[i] &&
                     (na_endereco_in[ADR_WIDTH*i +: ADR_WIDTH] == endereco_in);
      free_vec[i]  = ~na_ativo_in[i];
    end
  end

  // Isolating the lowest set bit gives the fixed-priority pick and is one-hot by construction.
  assign match_sel = match_vec & (~match_vec + NUM_NA'(1));
  assign free_sel  = free_vec & (~free_vec + NUM_NA'(1));

  always_comb begin
    habilitar_d = '0;
    if (desativar_in) begin
      habilitar_d = match_sel;
    end else if (atualizar_in) begin
      // Refresh an existing entry before ever allocating, so no address is duplicated.
      habilitar_d = (|match_vec) ? match_sel : free_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      habilitar_q <= '0;
    end else begin
      habilitar_q <= habilitar_d;
    end
  end

  assign habilitar_out = habilitar_q;

endmodule

// File: tb/tb_gerenciador_ativos_ctrl.sv
// Scoreboard bench for gerenciador_ativos_ctrl: directed scenarios plus random traffic.
module tb_gerenciador_ativos_ctrl;

  localparam int NA = 8;
  localparam int AW = 5;

  logic            clk;
  logic            rst_n;
  logic            desativar_in;
  logic            atualizar_in;
  logic [AW-1:0]   endereco_in;
  logic [AW*NA-1:0] na_endereco_in;
  logic [NA-1:0]   na_ativo_in;
  logic [NA-1:0]   habilitar_out;

  int checks;
  int errors;

  logic [NA-1:0] exp_q[$];
  string         tag_q[$];
  int            slot_adr[NA];

  gerenciador_ativos_ctrl #(
    .NUM_NA   (NA),
    .ADR_WIDTH(AW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .desativar_in  (desativar_in),
    .atualizar_in  (atualizar_in),
    .endereco_in   (endereco_in),
    .na_endereco_in(na_endereco_in),
    .na_ativo_in   (na_ativo_in),
    .habilitar_out (habilitar_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: scan from the top down so the last hit kept is the lowest index.
  function automatic logic [NA-1:0] model(input logic des, input logic atu,
                                          input logic [AW-1:0] adr, input logic [NA-1:0] act);
    logic [NA-1:0] hit;
    logic [NA-1:0] fr;
    hit = '0;
    fr  = '0;
    for (int i = NA - 1; i >= 0; i--) begin
      if (act[i] && (slot_adr[i] == int'(adr))) hit = NA'(1) << i;
      if (!act[i]) fr = NA'(1) << i;
    end
    if (des) return hit;
    if (atu) return (hit != '0) ? hit : fr;
    return '0;
  endfunction

  task automatic drive(input string tag, input logic des, input logic atu,
                       input logic [AW-1:0] adr, input logic [NA-1:0] act);
    @(negedge clk);
    desativar_in = des;
    atualizar_in = atu;
    endereco_in  = adr;
    na_ativo_in  = act;
    for (int i = 0; i < NA; i++) na_endereco_in[AW*i +: AW] = AW'(slot_adr[i]);
    exp_q.push_back(model(des, atu, adr, act));
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    check_eq(tag_q.pop_front(), habilitar_out, exp_q.pop_front());
    check_eq({tag, "_onehot"}, $onehot0(habilitar_out), 1);
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst_n          = 1'b0;
    desativar_in   = 1'b0;
    atualizar_in   = 1'b0;
    endereco_in    = '0;
    na_ativo_in    = '0;
    na_endereco_in = '0;
    for (int i = 0; i < NA; i++) slot_adr[i] = 0;

    @(posedge clk);
    #1;
    check_eq("reset", habilitar_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    drive("alloc0", 1'b0, 1'b1, 5'd5, 8'h00);
    check_eq("alloc0_abs", habilitar_out, 8'h01);
    drive("alloc0_idle", 1'b0, 1'b0, 5'd5, 8'h00);
    check_eq("alloc0_idle_abs", habilitar_out, 8'h00);

    slot_adr[0] = 5;
    drive("alloc1", 1'b0, 1'b1, 5'd7, 8'h01);
    check_eq("alloc1_abs", habilitar_out, 8'h02);
    slot_adr[1] = 7;
    drive("alloc2", 1'b0, 1'b1, 5'd9, 8'h03);
    check_eq("alloc2_abs", habilitar_out, 8'h04);
    slot_adr[2] = 9;

    drive("refresh", 1'b0, 1'b1, 5'd9, 8'h07);
    check_eq("refresh_abs", habilitar_out, 8'h04);
    drive("deact_hit", 1'b1, 1'b0, 5'd5, 8'h07);
    check_eq("deact_hit_abs", habilitar_out, 8'h01);
    drive("deact_miss", 1'b1, 1'b0, 5'd12, 8'h07);
    check_eq("deact_miss_abs", habilitar_out, 8'h00);

    for (int i = 0; i < NA; i++) slot_adr[i] = i;
    drive("full", 1'b0, 1'b1, 5'd20, 8'hFF);
    check_eq("full_abs", habilitar_out, 8'h00);
    drive("inactive_adr", 1'b0, 1'b1, 5'd3, 8'hF7);
    check_eq("inactive_adr_abs", habilitar_out, 8'h08);

    // Duplicate address in two slots: lowest active one must win.
    slot_adr[6] = 1;
    drive("dup_low", 1'b1, 1'b0, 5'd1, 8'hFF);
    check_eq("dup_low_abs", habilitar_out, 8'h02);
    drive("dup_skip", 1'b0, 1'b1, 5'd1, 8'hFD);
    check_eq("dup_skip_abs", habilitar_out, 8'h40);

    // Back-to-back requests give consecutive pulses.
    drive("b2b_a", 1'b0, 1'b1, 5'd4, 8'hFF);
    drive("b2b_b", 1'b0, 1'b1, 5'd5, 8'hFF);
    check_eq("b2b_b_abs", habilitar_out, 8'h20);

    slot_adr[0] = 5;
    slot_adr[1] = 7;
    slot_adr[2] = 9;
    drive("both", 1'b1, 1'b1, 5'd9, 8'h07);
    check_eq("both_abs", habilitar_out, 8'h04);
    drive("both_miss", 1'b1, 1'b1, 5'd11, 8'h07);
    check_eq("both_miss_abs", habilitar_out, 8'h00);

    drive("pre_rst", 1'b1, 1'b1, 5'd9, 8'h07);
    check_eq("pre_rst_abs", habilitar_out, 8'h04);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst", habilitar_out, 8'h00);
    @(negedge clk);
    desativar_in = 1'b0;
    atualizar_in = 1'b0;
    @(posedge clk);
    #1;
    check_eq("rst_hold", habilitar_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < 60; n++) begin
      logic d;
      logic a;
      for (int i = 0; i < NA; i++) slot_adr[i] = $urandom_range(0, 3);
      d = ($urandom_range(0, 3) == 0);
      a = ($urandom_range(0, 1) == 1);
      drive("rand", d, a, AW'($urandom_range(0, 4)), NA'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
